escalonador_mux4: RTL and testbench

Synchronous controller that shares the 4:1 data multiplexer (inputs X0..X3, selects A/B, output SAIDA) among four requesters. It arbitrates pending requests, drives the A/B selects for a programmable settle time, samples the multiplexer output into a holding register, and delivers it through a valid/ready handshake. It sits directly above the 4:1 multiplexer and replaces the free-running select stimulus used so far.

---
 rtl/escalonador_mux4_if.sv | 23 ++
 rtl/escalonador_mux4.sv | 142 ++++++++++++++
 tb/tb_escalonador_mux4.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/escalonador_mux4_if.sv
// Bus between the mux scheduler and its environment: requests, mux feedback,
// select/grant outputs and the sample handshake.
interface escalonador_mux4_if;
   logic [3:0] req;
   logic       saida_mux;
   logic       pronto;
   logic       a;
   logic       b;
   logic [3:0] gnt;
   logic       amostra;
   logic       valido;
   logic       ocupado;

   modport master (
      input  req, saida_mux, pronto,
      output a, b, gnt, amostra, valido, ocupado
   );

   modport slave (
      output req, saida_mux, pronto,
      input  a, b, gnt, amostra, valido, ocupado
   );
endinterface

// File: rtl/escalonador_mux4.sv
// Shares a 4:1 mux among four requesters: arbitrate, settle selects, sample, deliver.
// Optional macro ESCALONADOR_PRIO_FIXA_EN selects fixed priority (X0 highest) instead of round-robin.
module escalonador_mux4 #(
   parameter int DWELL = 4,
   parameter int CW    = 8
) (
   input logic               clock,
   input logic               reset,
   escalonador_mux4_if.master bus
);

   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      SELECIONA = 2'd1,
      ENTREGA   = 2'd2
   } estado_t;

   localparam int            DWELL_EF  = (DWELL < 1) ? 1 : DWELL;
   localparam logic [CW-1:0] CNT_CARGA = CW'(DWELL_EF - 1);

   estado_t       estado_reg, estado_next;
   logic [1:0]    cur_reg, cur_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          a_reg, a_next;
   logic          b_reg, b_next;
   logic [3:0]    gnt_reg, gnt_next;
   logic          amostra_reg, amostra_next;
   logic          valido_reg, valido_next;
   logic          avanca;
   logic [1:0]    base;
   logic [3:0]    req_rot;
   logic [1:0]    desloc;
   logic [1:0]    escolha;

`ifdef ESCALONADOR_PRIO_FIXA_EN
   assign base = 2'd0;
`else
   logic [1:0] ptr_reg;

   assign base = ptr_reg;

   always_ff @(posedge clock) begin
      if (reset)
         ptr_reg <= 2'd0;
      else if (avanca)
         ptr_reg <= cur_reg + 2'd1;
   end
`endif

   // Requests rotated so that bit 0 is the channel where the search begins.
   for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign req_rot[gi] = bus.req[base + 2'(gi)];
   end

   always_comb begin
      desloc = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (req_rot[i])
            desloc = 2'(i);
      end
   end

   assign escolha = base + desloc;

   always_comb begin
      estado_next  = estado_reg;
      cur_next     = cur_reg;
      cnt_next     = cnt_reg;
      a_next       = a_reg;
      b_next       = b_reg;
      gnt_next     = gnt_reg;
      amostra_next = amostra_reg;
      valido_next  = valido_reg;
      avanca       = 1'b0;
      case (estado_reg)
         OCIOSO: begin
            if (bus.req != 4'd0) begin
               cur_next          = escolha;
               {a_next, b_next}  = escolha;
               gnt_next          = 4'b0001 << escolha;
               cnt_next          = CNT_CARGA;
               estado_next       = SELECIONA;
            end
         end
         SELECIONA: begin
            // A withdrawn request wins over a sample falling due on the same edge.
            if (!bus.req[cur_reg]) begin
               gnt_next    = 4'd0;
               avanca      = 1'b1;
               estado_next = OCIOSO;
            end else if (cnt_reg == '0) begin
               amostra_next = bus.saida_mux;
               valido_next  = 1'b1;
               estado_next  = ENTREGA;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         ENTREGA: begin
            if (valido_reg && bus.pronto) begin
               valido_next = 1'b0;
               gnt_next    = 4'd0;
               avanca      = 1'b1;
               estado_next = OCIOSO;
            end
         end
         default: begin
            estado_next = OCIOSO;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_reg  <= OCIOSO;
         cur_reg     <= 2'd0;
         cnt_reg     <= '0;
         a_reg       <= 1'b0;
         b_reg       <= 1'b0;
         gnt_reg     <= 4'd0;
         amostra_reg <= 1'b0;
         valido_reg  <= 1'b0;
      end else begin
         estado_reg  <= estado_next;
         cur_reg     <= cur_next;
         cnt_reg     <= cnt_next;
         a_reg       <= a_next;
         b_reg       <= b_next;
         gnt_reg     <= gnt_next;
         amostra_reg <= amostra_next;
         valido_reg  <= valido_next;
      end
   end

   assign bus.a       = a_reg;
   assign bus.b       = b_reg;
   assign bus.gnt     = gnt_reg;
   assign bus.amostra = amostra_reg;
   assign bus.valido  = valido_reg;
   assign bus.ocupado = (estado_reg != OCIOSO);

endmodule

// File: tb/tb_escalonador_mux4.sv
// Scoreboard bench for escalonador_mux4: a transaction-level model predicts grant,
// abort and delivery events (with their edge numbers) plus per-cycle busy/valid.
module tb_escalonador_mux4;

   localparam int DWELL = 4;
   localparam int D     = (DWELL < 1) ? 1 : DWELL;

   localparam int EV_GRANT = 0;
   localparam int EV_ABORT = 1;
   localparam int EV_DELIV = 2;

   typedef struct {
      int kind;
      int chan;
      int t;
      int data;
   } evento_t;

   typedef struct {
      bit rst;
      bit busy;
      bit valid;
   } status_t;

   logic       clock = 1'b1;
   logic       reset;
   logic [3:0] xbits;

   always #5 clock = ~clock;

   escalonador_mux4_if sif ();

   assign sif.saida_mux = xbits[{sif.a, sif.b}];

   escalonador_mux4 #(.DWELL(DWELL), .CW(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (sif)
   );

   evento_t ev_q[$];
   status_t st_q[$];
   int      cyc  = 0;
   bit      done = 1'b0;
   int      n_cmp = 0;
   int      n_err = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Reference model state
   int m_ptr  = 0;
   bit m_busy = 1'b0;
   int m_chan = 0;
   int m_gt   = 0;
   bit m_deliv = 1'b0;
   int m_dado = 0;

   // Drive one cycle of inputs and advance the model for the coming edge.
   task automatic passo(input logic [3:0] r, input bit p, input bit rst);
      int  t;
      int  first;
      int  c;
      int  start;
      evento_t e;
      status_t s;
      @(negedge clock);
      reset     = rst;
      sif.req   = r;
      sif.pronto = p;
      xbits     = 4'($urandom);
      t = cyc + 1;
      if (rst) begin
         m_busy  = 1'b0;
         m_deliv = 1'b0;
         m_ptr   = 0;
      end else if (!m_busy) begin
         if (r != 4'd0) begin
`ifdef ESCALONADOR_PRIO_FIXA_EN
            start = 0;
`else
            start = m_ptr;
`endif
            first = -1;
            for (int k = 0; k < 4; k++) begin
               c = (start + k) % 4;
               if (first < 0 && r[c]) first = c;
            end
            m_chan  = first;
            m_gt    = t;
            m_busy  = 1'b1;
            m_deliv = 1'b0;
            e = '{EV_GRANT, first, t, 0};
            ev_q.push_back(e);
         end
      end else if (!m_deliv) begin
         if (!r[m_chan]) begin
            e = '{EV_ABORT, m_chan, t, 0};
            ev_q.push_back(e);
            m_ptr  = (m_chan + 1) % 4;
            m_busy = 1'b0;
         end else if (t == m_gt + D) begin
            m_dado  = int'(xbits[m_chan]);
            m_deliv = 1'b1;
         end
      end else if (p) begin
         e = '{EV_DELIV, m_chan, t, m_dado};
         ev_q.push_back(e);
         m_ptr   = (m_chan + 1) % 4;
         m_busy  = 1'b0;
         m_deliv = 1'b0;
      end
      s = '{rst, m_busy, m_busy && m_deliv};
      st_q.push_back(s);
   endtask

   function automatic int chan_de(input logic [3:0] g, input logic a, input logic b);
      int idx;
      idx = 9;
      for (int i = 0; i < 4; i++) begin
         if (g == (4'b0001 << i)) idx = i;
      end
      if (idx != 9 && idx != int'({a, b})) idx = 8;
      return idx;
   endfunction

   // Stimulus
   initial begin
      reset      = 1'b1;
      sif.req    = 4'd0;
      sif.pronto = 1'b0;
      xbits      = 4'd0;
      repeat (2) passo(4'b0000, 1'b0, 1'b1);
      repeat (8) passo(4'b0100, 1'b1, 1'b0);
      repeat (2) passo(4'b0000, 1'b1, 1'b0);
      repeat (30) passo(4'b1111, 1'b1, 1'b0);
      repeat (16) passo(4'b1111, 1'b0, 1'b0);
      repeat (3) passo(4'b1111, 1'b1, 1'b0);
      repeat (2) passo(4'b0000, 1'b0, 1'b1);
      repeat (3) passo(4'b0110, 1'b1, 1'b0);
      repeat (10) passo(4'b0100, 1'b1, 1'b0);
      repeat (8) passo(4'b1111, 1'b0, 1'b0);
      repeat (2) passo(4'b1111, 1'b0, 1'b1);
      repeat (8) passo(4'b1111, 1'b1, 1'b0);
      repeat (2) passo(4'b1010, 1'b1, 1'b0);
      begin
         logic [3:0] r;
         r = 4'd0;
         for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) r = 4'($urandom);
            passo(r, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
         end
      end
      repeat (12) passo(4'b0000, 1'b1, 1'b0);
      @(posedge clock);
      #2;
      done = 1'b1;
   end

   // Monitor
   initial begin
      status_t    s;
      evento_t    exp_e;
      evento_t    obs;
      bit         got;
      logic [3:0] p_gnt;
      logic       p_a, p_b, p_valido, p_amostra;
      p_gnt = 4'd0; p_a = 1'b0; p_b = 1'b0; p_valido = 1'b0; p_amostra = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         if (done) begin
            n_cmp++;
            if (ev_q.size() != 0) begin
               n_err++;
               $display("FAIL leftover: %0d expected events never seen, required 0", ev_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
         end
         if (st_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL status_q: edge %0d without expectation", cyc);
         end else begin
            s = st_q.pop_front();
            n_cmp++;
            if (sif.ocupado !== s.busy || sif.valido !== s.valid) begin
               n_err++;
               $display("FAIL status t=%0d: ocupado=%b valido=%b, required ocupado=%b valido=%b",
                        cyc, sif.ocupado, sif.valido, s.busy, s.valid);
            end
            if (s.rst) begin
               n_cmp++;
               if ({sif.a, sif.b, sif.gnt, sif.amostra} !== 7'd0) begin
                  n_err++;
                  $display("FAIL reset t=%0d: a=%b b=%b gnt=%b amostra=%b, required all 0",
                           cyc, sif.a, sif.b, sif.gnt, sif.amostra);
               end
            end else begin
               got = 1'b0;
               obs = '{0, 0, cyc, 0};
               if (p_valido && !sif.valido) begin
                  got = 1'b1;
                  obs = '{EV_DELIV, chan_de(p_gnt, p_a, p_b), cyc, int'(p_amostra)};
               end else if (p_gnt != 4'd0 && sif.gnt == 4'd0) begin
                  got = 1'b1;
                  obs = '{EV_ABORT, chan_de(p_gnt, p_a, p_b), cyc, 0};
               end else if (p_gnt == 4'd0 && sif.gnt != 4'd0) begin
                  got = 1'b1;
                  obs = '{EV_GRANT, chan_de(sif.gnt, sif.a, sif.b), cyc, 0};
               end
               if (got) begin
                  n_cmp++;
                  if (ev_q.size() == 0) begin
                     n_err++;
                     $display("FAIL event t=%0d: kind=%0d chan=%0d unexpected, required none",
                              cyc, obs.kind, obs.chan);
                  end else begin
                     exp_e = ev_q.pop_front();
                     if (obs != exp_e) begin
                        n_err++;
                        $display("FAIL event: got kind=%0d chan=%0d t=%0d data=%0d, required kind=%0d chan=%0d t=%0d data=%0d",
                                 obs.kind, obs.chan, obs.t, obs.data,
                                 exp_e.kind, exp_e.chan, exp_e.t, exp_e.data);
                     end else begin
                        $display("event kind=%0d chan=%0d t=%0d data=%0d ok",
                                 obs.kind, obs.chan, obs.t, obs.data);
                     end
                  end
               end
            end
         end
         p_gnt     = sif.gnt;
         p_a       = sif.a;
         p_b       = sif.b;
         p_valido  = sif.valido;
         p_amostra = sif.amostra;
      end
   end

endmodule
